// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-port RAM between instruction fetch and data access; data wins, fairness caps fetch starvation.
// Latency : grant is combinational in the request cycle; the valid pulse comes RD_LAT cycles later; one access per RD_LAT+1 cycles.
// Backpr. : no handshake; a requester holds its request and is stalled (stall_f/stall_m) until its valid pulse.
// Ports   : clk/resetn (sync, active low); if_req/if_addr -> if_rdata/if_valid (fetch);
//           dm_req/dm_we/dm_addr/dm_wdata -> dm_rdata/dm_valid (data);
//           mem_en/mem_we/mem_addr/mem_din -> RAM, mem_dout <- RAM; stall_f/stall_m to the pipeline.
module mem_port_arbiter #(
  parameter int RD_LAT = 1,
  parameter int MEM_AW = 12,
  parameter int FAIR_N = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic              stall_f,
  output logic              stall_m
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);
  localparam logic [3:0] FAIR_MAX = 4'(FAIR_N);

  state_t     state, state_nxt;
  owner_t     owner, owner_nxt;
  logic [2:0] lat_cnt, lat_nxt;
  logic [3:0] fair_cnt, fair_nxt;
  logic       grant_dm, grant_if;

  // Byte-offset bits and bits above the RAM word range are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:MEM_AW+2], if_addr[1:0], dm_addr[31:MEM_AW+2], dm_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      owner    <= OWN_NONE;
      lat_cnt  <= '0;
      fair_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      lat_cnt  <= lat_nxt;
      fair_cnt <= fair_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    lat_nxt   = lat_cnt;
    fair_nxt  = fair_cnt;
    grant_dm  = 1'b0;
    grant_if  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 4'h0;
    mem_addr  = '0;
    mem_din   = '0;
    if_valid  = 1'b0;
    dm_valid  = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;

    case (state)
      S_IDLE: begin
        // Data wins unless fetch has already been passed over FAIR_N times in a row.
        grant_dm = dm_req && !(if_req && (fair_cnt == FAIR_MAX));
        grant_if = !grant_dm && if_req;
        if (grant_dm) begin
          mem_en    = 1'b1;
          mem_addr  = dm_addr[MEM_AW+1:2];
          mem_we    = dm_we ? 4'hF : 4'h0;
          mem_din   = dm_wdata;
          owner_nxt = OWN_DM;
        end else if (grant_if) begin
          mem_en    = 1'b1;
          mem_addr  = if_addr[MEM_AW+1:2];
          owner_nxt = OWN_IF;
        end
        if (grant_dm || grant_if) begin
          state_nxt = S_WAIT;
          lat_nxt   = LAT_LOAD;
        end
        if (!if_req || grant_if) begin
          fair_nxt = '0;
        end else if (grant_dm && (fair_cnt != FAIR_MAX)) begin
          fair_nxt = fair_cnt + 4'd1;
        end
      end
      S_WAIT: begin
        if (lat_cnt != 3'd0) begin
          lat_nxt = lat_cnt - 3'd1;
        end else begin
          // Completes even if the requester dropped its request meanwhile.
          state_nxt = S_IDLE;
          owner_nxt = OWN_NONE;
          if (owner == OWN_IF) begin
            if_valid = 1'b1;
            if_rdata = mem_dout;
          end
          if (owner == OWN_DM) begin
            dm_valid = 1'b1;
            dm_rdata = mem_dout;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // In reset everything is quiet; an in-flight access is abandoned without a pulse.
    if (!resetn) begin
      mem_en   = 1'b0;
      mem_we   = 4'h0;
      mem_addr = '0;
      mem_din  = '0;
      if_valid = 1'b0;
      dm_valid = 1'b0;
      if_rdata = '0;
      dm_rdata = '0;
    end
  end

  assign stall_f = if_req & ~if_valid;
  assign stall_m = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        is_if;
    logic        has_data;
    logic [31:0] data;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- main DUT, RD_LAT=1
  logic        resetn, if_req, if_valid, dm_req, dm_we, dm_valid, mem_en, stall_f, stall_m;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_din, mem_dout;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;
  bit   [31:0] ram [4096];
  exp_t        if_q[$];
  exp_t        dm_q[$];

  mem_port_arbiter #(.RD_LAT(1), .MEM_AW(12), .FAIR_N(4)) u_dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .stall_f(stall_f), .stall_m(stall_m)
  );

  always @(posedge clk) begin
    if (!resetn) begin
      ram[2]  <= 32'h00500093;
      ram[4]  <= 32'h11111111;
      ram[16] <= 32'h22222222;
    end else if (mem_en) begin
      mem_dout <= ram[mem_addr];
      if (mem_we == 4'hF) ram[mem_addr] <= mem_din;
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (if_valid) begin
      chk("if_q_avail", 32'(if_q.size() != 0), 1);
      if (if_q.size() != 0) begin
        e = if_q.pop_front();
        chk("if_rdata", if_rdata, e.data);
      end
    end else begin
      chk("if_rdata_idle", if_rdata, 0);
    end
    if (dm_valid) begin
      chk("dm_q_avail", 32'(dm_q.size() != 0), 1);
      if (dm_q.size() != 0) begin
        e = dm_q.pop_front();
        if (e.has_data) chk("dm_rdata", dm_rdata, e.data);
      end
    end else begin
      chk("dm_rdata_idle", dm_rdata, 0);
    end
  end

  // ---------------------------------------------------------------- RD_LAT=3 DUT
  logic        t5_resetn, t5_if_req, t5_if_valid, t5_dm_req, t5_dm_we, t5_dm_valid;
  logic        t5_mem_en, t5_stall_f, t5_stall_m;
  logic [31:0] t5_if_addr, t5_if_rdata, t5_dm_addr, t5_dm_wdata, t5_dm_rdata, t5_mem_din, t5_mem_dout;
  logic [3:0]  t5_mem_we, t5_mem_addr;
  bit   [31:0] t5_ram [16];
  bit   [31:0] t5_pipe [3];
  exp_t        t5_q[$];
  bit          t5_done = 1'b0;

  mem_port_arbiter #(.RD_LAT(3), .MEM_AW(4), .FAIR_N(4)) u_t5 (
    .clk(clk), .resetn(t5_resetn),
    .if_req(t5_if_req), .if_addr(t5_if_addr), .if_rdata(t5_if_rdata), .if_valid(t5_if_valid),
    .dm_req(t5_dm_req), .dm_we(t5_dm_we), .dm_addr(t5_dm_addr), .dm_wdata(t5_dm_wdata),
    .dm_rdata(t5_dm_rdata), .dm_valid(t5_dm_valid),
    .mem_en(t5_mem_en), .mem_we(t5_mem_we), .mem_addr(t5_mem_addr), .mem_din(t5_mem_din),
    .mem_dout(t5_mem_dout), .stall_f(t5_stall_f), .stall_m(t5_stall_m)
  );

  always @(posedge clk) begin
    if (!t5_resetn) begin
      t5_ram[2] <= 32'hCAFEF00D;
      t5_ram[1] <= 32'h0BADBEEF;
    end else if (t5_mem_en && t5_mem_we == 4'hF) begin
      t5_ram[t5_mem_addr] <= t5_mem_din;
    end
    if (t5_mem_en) t5_pipe[0] <= t5_ram[t5_mem_addr];
    t5_pipe[1] <= t5_pipe[0];
    t5_pipe[2] <= t5_pipe[1];
  end
  assign t5_mem_dout = t5_pipe[2];

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (t5_if_valid || t5_dm_valid) begin
      chk("t5_q_avail", 32'(t5_q.size() != 0), 1);
      if (t5_q.size() != 0) begin
        e = t5_q.pop_front();
        chk("t5_owner", 32'(t5_if_valid), 32'(e.is_if));
        chk("t5_rdata", t5_if_valid ? t5_if_rdata : t5_dm_rdata, e.data);
      end
    end
  end

  initial begin
    int n;
    t5_resetn = 1'b0; t5_if_req = 1'b0; t5_if_addr = '0;
    t5_dm_req = 1'b0; t5_dm_we = 1'b0; t5_dm_addr = '0; t5_dm_wdata = '0;
    repeat (3) tick();
    t5_resetn = 1'b1;
    t5_dm_req = 1'b1; t5_dm_addr = 32'h8;
    @(negedge clk);
    chk("t5_issue_en", 32'(t5_mem_en), 1);
    chk("t5_issue_addr", 32'(t5_mem_addr), 2);
    t5_q.push_back('{1'b0, 1'b1, 32'hCAFEF00D});
    tick();
    t5_dm_req = 1'b0;                 // flushed after one cycle
    t5_if_req = 1'b1; t5_if_addr = 32'h4;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk("t5_wait_valid", 32'(t5_dm_valid), 0);
      chk("t5_wait_en", 32'(t5_mem_en), 0);
      tick();
    end
    @(negedge clk);
    chk("t5_dm_valid_lat3", 32'(t5_dm_valid), 1);
    chk("t5_no_grant_at_pulse", 32'(t5_mem_en), 0);
    chk("t5_stall_f", 32'(t5_stall_f), 1);
    tick();
    @(negedge clk);
    chk("t5_next_grant_en", 32'(t5_mem_en), 1);
    chk("t5_next_grant_addr", 32'(t5_mem_addr), 1);
    t5_q.push_back('{1'b1, 1'b1, 32'h0BADBEEF});
    n = 0;
    do begin
      tick();
      @(negedge clk);
      n++;
    end while (!t5_if_valid && n < 10);
    chk("t5_if_lat", n, 3);
    tick();
    t5_if_req = 1'b0;
    repeat (2) tick();
    chk("t5_q_drained", t5_q.size(), 0);
    t5_done = 1'b1;
  end

  // ---------------------------------------------------------------- RD_LAT sweep, random traffic
  bit sw_done [7];

  for (genvar gi = 0; gi < 7; gi++) begin : g_sw
    localparam int L  = gi + 1;
    localparam int FN = 1 + 2 * gi;

    logic        resetn, if_req, if_valid, dm_req, dm_we, dm_valid, mem_en, stall_f, stall_m;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_din, mem_dout;
    logic [3:0]  mem_we, mem_addr;
    bit   [31:0] ram [16];
    bit   [31:0] shadow [16];
    bit   [31:0] pipe [L];
    exp_t        q[$];
    bit          m_busy, m_own_if;
    int          m_lat, m_fair;

    mem_port_arbiter #(.RD_LAT(L), .MEM_AW(4), .FAIR_N(FN)) u_dut (
      .clk(clk), .resetn(resetn),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_valid(dm_valid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout), .stall_f(stall_f), .stall_m(stall_m)
    );

    always @(posedge clk) begin
      if (mem_en) begin
        pipe[0] <= ram[mem_addr];
        if (mem_we == 4'hF) ram[mem_addr] <= mem_din;
      end
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_dout = pipe[L-1];

    // Reference model: decides grants from the arbitration rules and predicts pulses and read data.
    initial forever begin
      bit         vf, vd, en;
      logic [3:0] ea, ewe;
      exp_t       e;
      @(negedge clk);
      vf = 1'b0; vd = 1'b0; en = 1'b0; ea = '0; ewe = '0;
      if (!resetn) begin
        m_busy = 1'b0; m_lat = 0; m_fair = 0;
      end else if (m_busy) begin
        if (m_lat == 0) begin
          vf = m_own_if; vd = !m_own_if; m_busy = 1'b0;
        end else begin
          m_lat--;
        end
      end else begin
        if (dm_req && !(if_req && m_fair == FN)) begin
          en = 1'b1; ea = dm_addr[5:2]; ewe = dm_we ? 4'hF : 4'h0; m_own_if = 1'b0;
          q.push_back('{1'b0, !dm_we, shadow[ea]});
          if (dm_we) shadow[ea] = dm_wdata;
          m_fair = if_req ? ((m_fair < FN) ? m_fair + 1 : FN) : 0;
        end else if (if_req) begin
          en = 1'b1; ea = if_addr[5:2]; m_own_if = 1'b1;
          q.push_back('{1'b1, 1'b1, shadow[ea]});
          m_fair = 0;
        end else begin
          m_fair = 0;
        end
        if (en) begin
          m_busy = 1'b1; m_lat = L - 1;
        end
      end
      chk("sw_mem_en", 32'(mem_en), 32'(en));
      if (en) begin
        chk("sw_mem_addr", 32'(mem_addr), 32'(ea));
        chk("sw_mem_we", 32'(mem_we), 32'(ewe));
        if (ewe != 4'h0) chk("sw_mem_din", mem_din, dm_wdata);
      end
      chk("sw_if_valid", 32'(if_valid), 32'(vf));
      chk("sw_dm_valid", 32'(dm_valid), 32'(vd));
      chk("sw_stall_f", 32'(stall_f), 32'(if_req & !vf));
      chk("sw_stall_m", 32'(stall_m), 32'(dm_req & !vd));
      if (if_valid || dm_valid) begin
        chk("sw_q_avail", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("sw_owner", 32'(if_valid), 32'(e.is_if));
          if (e.has_data) chk("sw_rdata", if_valid ? if_rdata : dm_rdata, e.data);
        end
      end
      if (!if_valid) chk("sw_if_rdata_zero", if_rdata, 0);
      if (!dm_valid) chk("sw_dm_rdata_zero", dm_rdata, 0);
    end

    initial begin
      resetn = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      repeat (3) tick();
      resetn = 1'b1;
      for (int c = 0; c < 1500; c++) begin
        if (if_req) if_req = ($urandom_range(0, 15) != 0);
        else        if_req = ($urandom_range(0, 1) == 1);
        if (dm_req) dm_req = ($urandom_range(0, 15) != 0);
        else        dm_req = ($urandom_range(0, 1) == 1);
        if_addr  = $urandom;
        dm_addr  = $urandom;
        dm_we    = ($urandom_range(0, 2) == 0);
        dm_wdata = $urandom;
        tick();
      end
      if_req = 1'b0; dm_req = 1'b0;
      repeat (10) tick();
      chk("sw_q_drained", q.size(), 0);
      sw_done[gi] = 1'b1;
    end
  end

  // ---------------------------------------------------------------- directed sequence, main DUT
  initial begin
    int nd, n;
    logic fetch;
    resetn = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_if_valid", 32'(if_valid), 0);
    chk("rst_dm_valid", 32'(dm_valid), 0);
    tick();
    if_req = 1'b1; if_addr = 32'h8;
    @(negedge clk);
    chk("rst_hold_en", 32'(mem_en), 0);
    chk("rst_stall_f", 32'(stall_f), 1);
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("t1_grant_en", 32'(mem_en), 1);
    tick();
    resetn = 1'b0;                     // abandon the access just issued
    @(negedge clk);
    chk("t1_abandon_valid", 32'(if_valid), 0);
    tick();
    resetn = 1'b1;

    // fetch of 0x8
    @(negedge clk);
    chk("t2_en", 32'(mem_en), 1);
    chk("t2_addr", 32'(mem_addr), 2);
    chk("t2_we", 32'(mem_we), 0);
    chk("t2_stall_issue", 32'(stall_f), 1);
    if_q.push_back('{1'b1, 1'b1, 32'h00500093});
    tick();
    @(negedge clk);
    chk("t2_valid", 32'(if_valid), 1);
    chk("t2_stall_done", 32'(stall_f), 0);
    chk("t2_wait_en", 32'(mem_en), 0);
    tick();
    if_req = 1'b0;

    // store then load at 0x34
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h34; dm_wdata = 32'hA5;
    @(negedge clk);
    chk("t3_st_en", 32'(mem_en), 1);
    chk("t3_st_we", 32'(mem_we), 32'hF);
    chk("t3_st_addr", 32'(mem_addr), 13);
    chk("t3_st_din", mem_din, 32'hA5);
    chk("t3_st_stall", 32'(stall_m), 1);
    dm_q.push_back('{1'b0, 1'b0, 32'h0});
    tick();
    @(negedge clk);
    chk("t3_st_valid", 32'(dm_valid), 1);
    tick();
    dm_we = 1'b0;
    @(negedge clk);
    chk("t3_ld_we", 32'(mem_we), 0);
    chk("t3_ld_addr", 32'(mem_addr), 13);
    dm_q.push_back('{1'b0, 1'b1, 32'hA5});
    tick();
    @(negedge clk);
    chk("t3_ld_valid", 32'(dm_valid), 1);
    tick();

    // both requesting continuously: D,D,D,D,F,D,D,D,D,F
    dm_addr = 32'h40; if_req = 1'b1; if_addr = 32'h10;
    for (int k = 0; k < 10; k++) begin
      fetch = (k % 5 == 4);
      @(negedge clk);
      chk("t4_grant_en", 32'(mem_en), 1);
      chk("t4_grant_addr", 32'(mem_addr), fetch ? 32'd4 : 32'd16);
      if (fetch) if_q.push_back('{1'b1, 1'b1, 32'h11111111});
      else       dm_q.push_back('{1'b0, 1'b1, 32'h22222222});
      tick();
      @(negedge clk);
      chk("t4_valid_pair", 32'({if_valid, dm_valid}), fetch ? 32'd2 : 32'd1);
      chk("t4_wait_en", 32'(mem_en), 0);
      tick();
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (3) tick();
    chk("if_q_drained", if_q.size(), 0);
    chk("dm_q_drained", dm_q.size(), 0);

    n = 0;
    do begin
      nd = int'(t5_done);
      foreach (sw_done[i]) nd += int'(sw_done[i]);
      if (nd != 8) tick();
      n++;
    end while (nd != 8 && n < 5000);
    chk("all_done", nd, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
